// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute sequencer: registers ALU operands, waits an opcode-dependent
// settle time, then captures the 64-bit result. Optional divide-by-zero fast path: ALU_SEQ_DIVZERO_EN.
module alu_exec_sequencer #(
    parameter int SIMPLE_CYCLES = 1,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_opcode,
    input  logic [31:0] req_ra,
    input  logic [31:0] req_rb,
    output logic [31:0] alu_ra,
    output logic [31:0] alu_rb,
    output logic [4:0]  alu_opcode,
    input  logic [63:0] alu_rc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_z,
    output logic        rsp_wide,
    output logic        rsp_err,
    output logic [15:0] op_count
);
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       req_muldiv;
    logic       alu_muldiv;
    logic [3:0] load_cnt;

    assign req_muldiv = (req_opcode == OP_MUL) || (req_opcode == OP_DIV);
    assign alu_muldiv = (alu_opcode == OP_MUL) || (alu_opcode == OP_DIV);
    assign load_cnt   = req_muldiv ? 4'(MULDIV_CYCLES - 1) : 4'(SIMPLE_CYCLES - 1);

    // Handshake flags decode straight from the state register: no path from req_valid/rsp_ready.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);

`ifdef ALU_SEQ_DIVZERO_EN
    logic err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_ra     <= '0;
            alu_rb     <= '0;
            alu_opcode <= '0;
            rsp_z      <= '0;
            rsp_wide   <= 1'b0;
            op_count   <= '0;
`ifdef ALU_SEQ_DIVZERO_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_ra     <= req_ra;
                        alu_rb     <= req_rb;
                        alu_opcode <= req_opcode;
                        cnt        <= load_cnt;
                        state      <= EXEC;
`ifdef ALU_SEQ_DIVZERO_EN
                        err_q      <= 1'b0;
                        // Divide by zero never waits on the ALU; answer immediately.
                        if (req_opcode == OP_DIV && req_rb == 32'd0) begin
                            state    <= DONE;
                            rsp_z    <= '0;
                            rsp_wide <= 1'b1;
                            err_q    <= 1'b1;
                        end
`endif
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_z    <= alu_rc;
                        rsp_wide <= alu_muldiv;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state    <= IDLE;
                        op_count <= op_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a behavioural ALU and an expected-response queue.
`timescale 1ns/1ps
module tb_alu_exec_sequencer;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = '0;
    logic [31:0] req_ra = '0;
    logic [31:0] req_rb = '0;
    logic [31:0] alu_ra;
    logic [31:0] alu_rb;
    logic [4:0]  alu_opcode;
    logic [63:0] alu_rc;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_z;
    logic        rsp_wide;
    logic        rsp_err;
    logic [15:0] op_count;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [65:0] exp_q[$];

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    alu_exec_sequencer dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_ra(req_ra), .req_rb(req_rb),
        .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_opcode(alu_opcode), .alu_rc(alu_rc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
        .rsp_wide(rsp_wide), .rsp_err(rsp_err), .op_count(op_count)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: add, multiply, divide ({remainder, quotient}); 0 otherwise.
    always_comb begin
        alu_rc = '0;
        case (alu_opcode)
            OP_ADD: alu_rc = {32'd0, alu_ra + alu_rb};
            OP_MUL: alu_rc = {32'd0, alu_ra} * {32'd0, alu_rb};
            OP_DIV: alu_rc = (alu_rb == 0) ? 64'd0 : {alu_ra % alu_rb, alu_ra / alu_rb};
            default: alu_rc = '0;
        endcase
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_rsp(input string tag);
        logic [65:0] e;
        check({tag, "_q_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_z"}, rsp_z, e[63:0]);
            check({tag, "_wide"}, rsp_wide, e[64]);
            check({tag, "_err"}, rsp_err, e[65]);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            step();
            n++;
        end
    endtask

    // Issue one request with rsp_ready held high, check latency, result and handshake.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] z, input logic wide,
                          input logic err, input int lat);
        int n;
        rsp_ready  = 1'b1;
        req_opcode = op;
        req_ra     = a;
        req_rb     = b;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        check({tag, "_ready"}, req_ready, 1'b1);
        step();
        req_valid  = 1'b0;
        req_ra     = 32'hDEAD_BEEF;
        req_rb     = 32'hCAFE_F00D;
        req_opcode = 5'b11010;
        exp_q.push_back({err, wide, z});
        wait_rsp(n);
        check({tag, "_latency"}, 64'(n), 64'(lat));
        compare_rsp(tag);
        check({tag, "_alu_ra_held"}, alu_ra, a);
        check({tag, "_alu_op_held"}, alu_opcode, op);
        step();
        exp_cnt++;
        check({tag, "_rsp_dropped"}, rsp_valid, 1'b0);
        check({tag, "_op_count"}, op_count, 64'(exp_cnt));
    endtask

    initial begin
        int n;
        #2;
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_req_ready", req_ready, 1'b1);
        check("reset_alu_ra", alu_ra, 0);
        check("reset_alu_opcode", alu_opcode, 0);
        check("reset_rsp_z", rsp_z, 0);
        check("reset_op_count", op_count, 0);
        step();
        step();
        clear = 1'b1;
        step();

        run_op("add", OP_ADD, 32'd5, 32'd7, 64'd12, 1'b0, 1'b0, 1);
        run_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1, 1'b0, 4);
        run_op("div", OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, 1'b0, 4);
        run_op("unimpl", 5'b11111, 32'd9, 32'd9, 64'd0, 1'b0, 1'b0, 1);

        // Backpressure: response held while a second request waits.
        rsp_ready  = 1'b0;
        req_opcode = OP_ADD;
        req_ra     = 32'd1;
        req_rb     = 32'd2;
        req_valid  = 1'b1;
        step();
        req_ra = 32'd10;
        req_rb = 32'd20;
        exp_q.push_back({2'b00, 64'd3});
        wait_rsp(n);
        check("bp_latency", 64'(n), 64'd1);
        compare_rsp("bp_first");
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_z_stable", rsp_z, 64'd3);
            check("bp_req_ready_low", req_ready, 1'b0);
            check("bp_rsp_valid_held", rsp_valid, 1'b1);
        end
        rsp_ready = 1'b1;
        step();
        exp_cnt++;
        check("bp_hs_rsp_valid", rsp_valid, 1'b0);
        check("bp_hs_op_count", op_count, 64'(exp_cnt));
        check("bp_hs_req_ready", req_ready, 1'b1);
        check("bp_alu_ra_before_accept", alu_ra, 32'd1);
        step();
        req_valid = 1'b0;
        exp_q.push_back({2'b00, 64'd30});
        check("bp_second_accepted", req_ready, 1'b0);
        check("bp_second_alu_ra", alu_ra, 32'd10);
        wait_rsp(n);
        check("bp_second_latency", 64'(n), 64'd1);
        compare_rsp("bp_second");
        step();
        exp_cnt++;
        check("bp_second_op_count", op_count, 64'(exp_cnt));

        // Asynchronous clear two edges into a multiply.
        req_opcode = OP_MUL;
        req_ra     = 32'd3;
        req_rb     = 32'd4;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        #1 clear = 1'b0;
        #1;
        exp_cnt = 0;
        check("midreset_rsp_valid", rsp_valid, 1'b0);
        check("midreset_req_ready", req_ready, 1'b1);
        check("midreset_op_count", op_count, 0);
        check("midreset_alu_ra", alu_ra, 0);
        check("midreset_rsp_z", rsp_z, 0);
        check("midreset_rsp_wide", rsp_wide, 0);
        clear = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid) n++;
        end
        check("midreset_no_rsp", 64'(n), 64'd0);
        run_op("post_reset_add", OP_ADD, 32'd40, 32'd2, 64'd42, 1'b0, 1'b0, 1);

`ifdef ALU_SEQ_DIVZERO_EN
        run_op("divzero", OP_DIV, 32'd100, 32'd0, 64'd0, 1'b1, 1'b1, 0);
`else
        run_op("divzero", OP_DIV, 32'd100, 32'd0, 64'd0, 1'b1, 1'b0, 4);
`endif
        run_op("after_divzero", OP_ADD, 32'd1, 32'd1, 64'd2, 1'b0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
